// File: rtl/button_events.sv
// button_events: turns debounced button levels into press/release/hold/repeat
// events, queued in a small FIFO behind a valid/ready handshake.
// The BUTTON_EVENTS_REPEAT_EN macro enables repeat events while a lane is HELD.
// Without it, HELD is terminal until release.
module button_events #(
  parameter int unsigned NUM_BUTTONS   = 4,
  parameter int unsigned TICK_DIV_BITS = 15,
  parameter logic [7:0]  HOLD_TICKS    = 8'd24,
  parameter logic [7:0]  REPEAT_TICKS  = 8'd6,
  parameter int unsigned FIFO_DEPTH    = 4,
  localparam int unsigned IDX_W        = $clog2(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] button_in,
  output logic                   event_valid,
  output logic [1:0]             event_type,
  output logic [IDX_W-1:0]       event_index,
  input  logic                   event_ready,
  output logic [NUM_BUTTONS-1:0] held,
  output logic                   overflow,
  input  logic                   overflow_clr
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 2 + IDX_W;

  // Pending-flag bit positions; each position doubles as the event_type code.
  localparam int unsigned EV_PRESS   = 0;
  localparam int unsigned EV_RELEASE = 1;
  localparam int unsigned EV_HOLD    = 2;
  localparam int unsigned EV_REPEAT  = 3;

  if (HOLD_TICKS == 8'd0 || REPEAT_TICKS == 8'd0) begin : g_bad_ticks
    $error("button_events: HOLD_TICKS and REPEAT_TICKS must be in 1..255");
  end

  typedef enum logic [1:0] {S_IDLE, S_PRESSED, S_HELD} lane_state_t;

  logic [TICK_DIV_BITS-1:0] presc_q;
  logic                     tick;
  logic [NUM_BUTTONS-1:0]   button_q;
  logic [NUM_BUTTONS-1:0]   rise;
  logic [NUM_BUTTONS-1:0]   fall;

  lane_state_t state_q  [NUM_BUTTONS];
  lane_state_t state_d  [NUM_BUTTONS];
  logic [7:0]  cnt_q    [NUM_BUTTONS];
  logic [7:0]  cnt_d    [NUM_BUTTONS];
  logic [3:0]  pend_q   [NUM_BUTTONS];
  logic [3:0]  pend_d   [NUM_BUTTONS];
  logic [3:0]  pend_set [NUM_BUTTONS];
  logic        ovf_set;
  logic        overflow_q;

  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] push_data;

  function automatic logic [1:0] first_pending(input logic [3:0] p);
    logic [1:0] sel;
    if (p[EV_PRESS])        sel = 2'd0;
    else if (p[EV_RELEASE]) sel = 2'd1;
    else if (p[EV_HOLD])    sel = 2'd2;
    else                    sel = 2'd3;
    return sel;
  endfunction

  assign tick = &presc_q;
  assign rise = button_in & ~button_q;
  assign fall = ~button_in & button_q;

  // Free-running prescaler; tick is the single all-ones cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc_q <= '0;
    else        presc_q <= presc_q + 1'b1;
  end

  // Previous button levels for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) button_q <= '0;
    else        button_q <= button_in;
  end

  // Per-lane next state, tick counter and event requests; fall beats tick, rise resets cnt.
  always_comb begin
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      state_d[i]  = state_q[i];
      cnt_d[i]    = cnt_q[i];
      pend_set[i] = '0;
      unique case (state_q[i])
        S_IDLE: begin
          if (rise[i]) begin
            state_d[i]            = S_PRESSED;
            cnt_d[i]              = '0;
            pend_set[i][EV_PRESS] = 1'b1;
          end
        end
        S_PRESSED: begin
          if (fall[i]) begin
            state_d[i]              = S_IDLE;
            cnt_d[i]                = '0;
            pend_set[i][EV_RELEASE] = 1'b1;
          end else if (tick) begin
            if (cnt_q[i] == HOLD_TICKS - 8'd1) begin
              state_d[i]           = S_HELD;
              cnt_d[i]             = '0;
              pend_set[i][EV_HOLD] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
        end
        S_HELD: begin
          if (fall[i]) begin
            state_d[i]              = S_IDLE;
            cnt_d[i]                = '0;
            pend_set[i][EV_RELEASE] = 1'b1;
          end
`ifdef BUTTON_EVENTS_REPEAT_EN
          else if (tick) begin
            if (cnt_q[i] == REPEAT_TICKS - 8'd1) begin
              cnt_d[i]               = '0;
              pend_set[i][EV_REPEAT] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
`endif
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Scheduler: lowest lane first, press/release/hold/repeat order; the clear is
  // applied before new requests so a same-cycle re-set is not an overflow.
  always_comb begin
    push      = 1'b0;
    push_data = '0;
    ovf_set   = 1'b0;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      pend_d[i] = pend_q[i];
    end
    if (count_q < CNT_W'(FIFO_DEPTH)) begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        if (!push && (pend_q[i] != '0)) begin
          push                           = 1'b1;
          push_data                      = {first_pending(pend_q[i]), IDX_W'(i)};
          pend_d[i][first_pending(pend_q[i])] = 1'b0;
        end
      end
    end
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      if ((pend_set[i] & pend_d[i]) != '0) ovf_set = 1'b1;
      pend_d[i] = pend_d[i] | pend_set[i];
    end
  end

  // Lane state, counters and pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
        pend_q[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        pend_q[i]  <= pend_d[i];
      end
    end
  end

  // Sticky overflow; a new loss outranks the clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow_q <= 1'b0;
    else if (ovf_set)      overflow_q <= 1'b1;
    else if (overflow_clr) overflow_q <= 1'b0;
  end

  assign pop = (count_q != '0) && event_ready;

  // Event FIFO; write depends only on the pre-pop count, so no pass-through when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        fifo_mem[k] <= '0;
      end
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= push_data;
        wr_ptr_q           <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Output mapping.
  always_comb begin
    event_valid               = (count_q != '0);
    {event_type, event_index} = fifo_mem[rd_ptr_q];
    overflow                  = overflow_q;
    for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
      held[i] = (state_q[i] == S_HELD);
    end
  end

endmodule
